// File: rtl/message_printer.sv
// Collects WIDTH ASCII binary digits from a UART receiver, then streams
// "REV=<digits reversed>\r\n" to a UART transmitter, one byte per strobe.
module message_printer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    input  logic       new_rx_data,
    input  logic [7:0] rx_data
);

    localparam int unsigned MSG_LEN = WIDTH + 6;
    localparam int unsigned CW      = $clog2(WIDTH + 1);
    localparam int unsigned IW      = $clog2(MSG_LEN);

    typedef enum logic {COLLECT, PRINT} state_t;

    state_t           state;
    logic [WIDTH-1:0] digits;
    logic [CW-1:0]    count;
    logic [IW-1:0]    index;
    logic             gap;

    logic       is_digit_c;
    logic [7:0] msg_byte_c;

    assign is_digit_c = (rx_data == 8'h30) || (rx_data == 8'h31);

    // Message ROM: fixed prefix, digits newest-first, CR LF
    always_comb begin
        msg_byte_c = 8'h00;
        if (index == IW'(0))                msg_byte_c = 8'h52;
        else if (index == IW'(1))           msg_byte_c = 8'h45;
        else if (index == IW'(2))           msg_byte_c = 8'h56;
        else if (index == IW'(3))           msg_byte_c = 8'h3D;
        else if (index == IW'(MSG_LEN - 2)) msg_byte_c = 8'h0D;
        else if (index == IW'(MSG_LEN - 1)) msg_byte_c = 8'h0A;
        else begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                if (index == IW'(4 + j)) msg_byte_c = {7'b0011000, digits[WIDTH-1-j]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= COLLECT;
            digits      <= '0;
            count       <= '0;
            index       <= '0;
            gap         <= 1'b0;
            tx_data     <= 8'h00;
            new_tx_data <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            gap         <= 1'b0;
            case (state)
                COLLECT: begin
                    if (new_rx_data) begin
                        if (is_digit_c) begin
                            for (int unsigned j = 0; j < WIDTH; j++) begin
                                if (count == CW'(j)) digits[j] <= rx_data[0];
                            end
                            count <= count + CW'(1);
                            if (count == CW'(WIDTH - 1)) begin
                                state <= PRINT;
                                index <= '0;
                            end
                        end else begin
                            digits <= '0;
                            count  <= '0;
                        end
                    end
                end
                PRINT: begin
                    // gap forces an idle cycle so tx_busy has time to rise
                    if (!tx_busy && !gap) begin
                        tx_data     <= msg_byte_c;
                        new_tx_data <= 1'b1;
                        gap         <= 1'b1;
                        if (index == IW'(MSG_LEN - 1)) begin
                            state  <= COLLECT;
                            count  <= '0;
                            digits <= '0;
                            index  <= '0;
                        end else begin
                            index <= index + IW'(1);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_message_printer.sv
// Randomised and directed checks of message_printer against a queue-based
// model of the digit collection and message printing rules.
module tb_message_printer;

    localparam int unsigned WIDTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;
    logic       new_rx_data;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    message_printer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .new_tx_data(new_tx_data),
        .tx_busy    (tx_busy),
        .new_rx_data(new_rx_data),
        .rx_data    (rx_data)
    );

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [7:0] exp_q[$];
    bit         digs[$];
    logic [7:0] rx_log[$];
    bit         printing;
    int         accept_cyc;
    int         cyc;
    bit         prev_strobe;
    logic [7:0] last_tx;
    int         busy_mode;
    int         busy_left;
    int         msg_strobes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_rx(input logic [7:0] b);
        if (printing) return;
        if (b == 8'h30 || b == 8'h31) begin
            digs.push_back(b[0]);
            if (digs.size() == WIDTH) begin
                exp_q = '{8'h52, 8'h45, 8'h56, 8'h3D};
                for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(digs[i] ? 8'h31 : 8'h30);
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
                digs.delete();
                printing    = 1'b1;
                accept_cyc  = cyc + 1;
                msg_strobes = 0;
            end
        end else begin
            digs.delete();
        end
    endtask

    // One clock: drive inputs, advance, compare outputs with the model
    task automatic step(input bit v, input logic [7:0] b);
        bit          busy_now;
        bit          exp_strobe;
        logic [31:0] expb;
        case (busy_mode)
            1:       busy_now = (busy_left > 0);
            2:       busy_now = ($urandom_range(0, 2) == 0);
            default: busy_now = 1'b0;
        endcase
        tx_busy     = busy_now;
        new_rx_data = v;
        rx_data     = v ? b : 8'($urandom);
        if (v) model_rx(b);
        @(posedge clk);
        cyc++;
        #1;
        exp_strobe = printing && (cyc > accept_cyc) && !busy_now && !prev_strobe;
        check("strobe", new_tx_data, exp_strobe);
        if (new_tx_data === 1'b1) begin
            expb = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
            check("tx_byte", tx_data, expb);
            last_tx = expb[7:0];
            rx_log.push_back(tx_data);
            msg_strobes++;
            if (exp_q.size() == 0) printing = 1'b0;
        end else begin
            check("tx_hold", tx_data, last_tx);
        end
        if (exp_strobe) busy_left = 10;
        else if (busy_left > 0) busy_left--;
        prev_strobe = exp_strobe;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        new_rx_data = 1'b0;
        tx_busy     = 1'b0;
        rx_data     = 8'h00;
        #1;
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_strobe", new_tx_data, 1'b0);
        exp_q.delete();
        digs.delete();
        printing    = 1'b0;
        prev_strobe = 1'b0;
        last_tx     = 8'h00;
        busy_left   = 0;
        repeat (2) @(posedge clk);
        cyc += 2;
        #1;
        check("rst_hold_strobe", new_tx_data, 1'b0);
        rst = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && printing; i++) step(1'b0, 8'h00);
        check("drain_done", printing, 1'b0);
        repeat (3) step(1'b0, 8'h00);
    endtask

    task automatic expect_msg(input string s);
        check("msg_len", rx_log.size(), s.len());
        for (int i = 0; i < s.len() && i < rx_log.size(); i++) check("msg_char", rx_log[i], s[i]);
        rx_log.delete();
    endtask

    initial begin
        cyc       = 0;
        busy_mode = 0;
        busy_left = 0;
        do_reset();
        repeat (50) step(1'b0, 8'h00);
        check("idle_no_output", rx_log.size(), 0);

        busy_mode = 0;
        send(8'h31); send(8'h30); send(8'h30); send(8'h30);
        drain();
        expect_msg("REV=0001\r\n");

        busy_mode = 1;
        send(8'h31); send(8'h31); send(8'h30); send(8'h31);
        drain();
        expect_msg("REV=1011\r\n");

        busy_mode = 0;
        send(8'h31); send(8'h31); send(8'h78);
        send(8'h30); send(8'h30); send(8'h30); send(8'h31);
        drain();
        expect_msg("REV=1000\r\n");

        send(8'h30); send(8'h30); send(8'h31); send(8'h31);
        send(8'h31);
        drain();
        expect_msg("REV=1100\r\n");
        send(8'h30); send(8'h31); send(8'h30); send(8'h31);
        drain();
        expect_msg("REV=1010\r\n");

        send(8'h31); send(8'h30); send(8'h31); send(8'h30);
        for (int i = 0; i < 50 && msg_strobes < 3; i++) step(1'b0, 8'h00);
        check("pre_reset_strobes", msg_strobes, 3);
        do_reset();
        rx_log.delete();
        repeat (20) step(1'b0, 8'h00);
        check("post_reset_quiet", rx_log.size(), 0);
        send(8'h30); send(8'h31); send(8'h31); send(8'h31);
        drain();
        expect_msg("REV=1110\r\n");

        // random traffic: mostly digits, some junk, random busy and gaps
        for (int n = 0; n < 600; n++) begin
            logic [7:0] b;
            if (n % 100 == 0) busy_mode = $urandom_range(0, 2);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = 8'h30;
                4, 5, 6, 7: b = 8'h31;
                default:    b = 8'($urandom);
            endcase
            step($urandom_range(0, 2) != 0, b);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/message_printer.md
Name: message_printer

Overview:
- UART-side message generator for the bit-reversal demo.
- Collects ASCII binary digits ('0'/'1') received from a UART receiver.
- Once WIDTH digits are collected, it prints a fixed message containing the digits in reversed order through a UART transmitter.
- Sits between uart_rx outputs (new_rx_data/rx_data) and uart_tx inputs (new_tx_data/tx_data/tx_busy).

Parameters:
- WIDTH, 4, number of binary digits collected per message (1..8).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- tx_data  output  8  byte to transmit; valid when new_tx_data=1, held stable until the next pulse.
- new_tx_data  output  1  one-cycle strobe requesting transmission of tx_data.
- tx_busy  input  1  transmitter busy; no strobe may be issued while 1.
- new_rx_data  input  1  one-cycle strobe: rx_data holds a newly received byte.
- rx_data  input  8  received byte.

Behaviour:
- Reset (rst=0, async): state=COLLECT, digit buffer=0, digit count=0, char index=0, gap flag=0, tx_data=8'h00, new_tx_data=0.
- Message format, length WIDTH+6 bytes:
  - "REV=" (0x52 0x45 0x56 0x3D), then the WIDTH digits in reverse order of arrival, then CR LF (0x0D 0x0A).
  - The last-received digit is printed first; the first-received digit is printed last.
- COLLECT state:
  - new_rx_data=1 with rx_data=0x30 or 0x31: store the digit at position count; count+1.
  - If this makes count==WIDTH: go to PRINT next cycle with index=0; buffer is frozen.
  - new_rx_data=1 with any other byte: clear buffer and count (partial entry discarded), stay in COLLECT.
  - new_tx_data stays 0 throughout COLLECT.
- PRINT state:
  - Each cycle where tx_busy=0 and gap=0: drive tx_data=message[index], pulse new_tx_data=1 for exactly that cycle, index+1, gap=1.
  - gap clears the following cycle. This guarantees at least one idle cycle between strobes, covering the transmitter's one-cycle busy latency.
  - tx_busy=1: no strobe; wait, index unchanged.
  - After the strobe for the last byte (LF): return to COLLECT with count=0, buffer=0, index=0.
  - new_rx_data during PRINT is ignored; the byte is dropped and does not affect the buffer.
- Latency: the 4th valid digit is accepted at edge k. With tx_busy=0, the first strobe ("R") is high in the cycle after edge k+1. Subsequent strobes are at most every 2 cycles while tx_busy=0.
- Simultaneous: a digit strobe arriving on the same edge as the final LF strobe is dropped.
- Reset mid-PRINT: aborts immediately; the remaining bytes are never sent; buffer cleared.
- tx_data retains its last transmitted value between strobes; it is never X after reset.
- Implementation: a 2-state FSM plus a message ROM/mux indexed by index. Digit bits are mapped to 0x30|bit.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> tx_data=0x00, new_tx_data=0, no strobes for 50 cycles with no rx input.
- Digits '1','0','0','0' as 4 single-cycle new_rx_data pulses, tx_busy=0 -> exactly 10 strobes with bytes 52 45 56 3D 30 30 30 31 0D 0A; no two strobes in adjacent cycles.
- Digits '1','1','0','1' with tx_busy modelled high for 10 cycles after each strobe -> bytes 52 45 56 3D 31 30 31 31 0D 0A; never a strobe while tx_busy=1.
- Partial entry then invalid byte: '1','1','x'(0x78), then '0','0','0','1' -> single message "REV=1000\r\n"; the first two digits are discarded.
- Digits '0','0','1','1', then '1' sent during PRINT -> message "REV=1100\r\n"; the extra '1' is dropped. A subsequent '0','1','0','1' prints "REV=1010\r\n".
- Assert rst=0 after the 3rd strobe of a message -> strobes stop immediately and outputs reset. After release, a fresh 4-digit entry prints a complete 10-byte message.
